// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : Dual-issue scheduler sitting behind the instruction fetch
//               buffer. Decodes the RV32I instruction0/instruction1 pair,
//               checks operand hazards against a per-register load
//               scoreboard, intra-pair conflicts and execute back-pressure,
//               then registers 0, 1 or 2 instructions into the issue slots.
//
// Ports:
//   clk                 in   1   system clock
//   rst                 in   1   synchronous active-high reset
//   nothing_filled      in   1   fetch buffer empty; pair invalid
//   instruction0        in   32  oldest instruction (0 = empty)
//   instruction1        in   32  next instruction (0 = empty)
//   ex_stall            in   1   execute cannot accept new issue
//   freeze1             out  1   ins0 operand hazard; buffer holds
//   freeze2             out  1   execute back-pressure; buffer holds
//   dependency_on_ins2  out  1   ins0 issues alone; buffer slides by 1
//   issue0_valid        out  1   slot-0 valid
//   issue0_instr        out  32  slot-0 instruction
//   issue1_valid        out  1   slot-1 valid
//   issue1_instr        out  32  slot-1 instruction
//   issue_count         out  32  running count of issued instructions
//
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int LOAD_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        ex_stall,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr,
    output logic [31:0] issue_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_CNT_W    = $clog2(LOAD_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_SET = c_CNT_W'(LOAD_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    function automatic logic f_uses_rs1(input logic [6:0] op);
        return (op == c_OP_REG)  || (op == c_OP_STORE) || (op == c_OP_BRANCH) ||
               (op == c_OP_IMM)  || (op == c_OP_LOAD)  || (op == c_OP_JALR);
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] op);
        return (op == c_OP_REG) || (op == c_OP_STORE) || (op == c_OP_BRANCH);
    endfunction

    // A write to x0 is architecturally discarded, so it never counts.
    function automatic logic f_writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return (op != c_OP_STORE) && (op != c_OP_BRANCH) && (rd != 5'd0);
    endfunction

    function automatic logic f_is_mem(input logic [6:0] op);
        return (op == c_OP_LOAD) || (op == c_OP_STORE);
    endfunction

    function automatic logic f_is_ctrl(input logic [6:0] op);
        return (op == c_OP_BRANCH) || (op == c_OP_JAL) || (op == c_OP_JALR);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_sb [1:31];
    logic               r_issue0_valid;
    logic [31:0]        r_issue0_instr;
    logic               r_issue1_valid;
    logic [31:0]        r_issue1_instr;
    logic [31:0]        r_issue_count;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0] w_op0, w_op1;
    logic [4:0] w_rd0, w_rd1, w_rs1_0, w_rs1_1, w_rs2_0, w_rs2_1;

    assign w_op0   = instruction0[6:0];
    assign w_rd0   = instruction0[11:7];
    assign w_rs1_0 = instruction0[19:15];
    assign w_rs2_0 = instruction0[24:20];
    assign w_op1   = instruction1[6:0];
    assign w_rd1   = instruction1[11:7];
    assign w_rs1_1 = instruction1[19:15];
    assign w_rs2_1 = instruction1[24:20];

    // Busy vector; bit 0 stays clear so a source of x0 never hazards.
    logic [31:0] w_busy;
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < 32; i++) begin
            w_busy[i] = (r_sb[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Hazard and conflict detection
    // ------------------------------------------------------------------
    logic w_v0, w_v1;
    logic w_use1_0, w_use2_0, w_use1_1, w_use2_1;
    logic w_wr0, w_wr1;
    logic w_haz0, w_haz1;
    logic w_raw, w_waw, w_mem_pair, w_ctrl0;
    logic w_single;

    assign w_v0 = !nothing_filled && (instruction0 != 32'd0);
    assign w_v1 = w_v0 && (instruction1 != 32'd0);

    assign w_use1_0 = f_uses_rs1(w_op0);
    assign w_use2_0 = f_uses_rs2(w_op0);
    assign w_use1_1 = f_uses_rs1(w_op1);
    assign w_use2_1 = f_uses_rs2(w_op1);
    assign w_wr0    = f_writes_rd(w_op0, w_rd0);
    assign w_wr1    = f_writes_rd(w_op1, w_rd1);

    assign w_haz0 = (w_use1_0 && w_busy[w_rs1_0]) || (w_use2_0 && w_busy[w_rs2_0]);
    assign w_haz1 = (w_use1_1 && w_busy[w_rs1_1]) || (w_use2_1 && w_busy[w_rs2_1]);

    // ins1 cannot see ins0's result in the same issue group.
    assign w_raw = w_wr0 && ((w_use1_1 && (w_rs1_1 == w_rd0)) ||
                             (w_use2_1 && (w_rs2_1 == w_rd0)));
    assign w_waw      = w_wr0 && w_wr1 && (w_rd0 == w_rd1);
    // Single memory port in execute.
    assign w_mem_pair = f_is_mem(w_op0) && f_is_mem(w_op1);
    // Nothing younger than a control transfer issues alongside it.
    assign w_ctrl0    = f_is_ctrl(w_op0);

    assign w_single = !w_v1 || w_raw || w_waw || w_mem_pair || w_ctrl0 || w_haz1;

    // ------------------------------------------------------------------
    // Issue decision (priority ordered, outputs mutually exclusive)
    // ------------------------------------------------------------------
    logic w_iss0, w_iss1;

    always_comb begin
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        w_iss0             = 1'b0;
        w_iss1             = 1'b0;
        if (!w_v0) begin
            // empty pair: nothing to do
        end else if (ex_stall) begin
            freeze2 = 1'b1;
        end else if (w_haz0) begin
            freeze1 = 1'b1;
        end else if (w_single) begin
            dependency_on_ins2 = 1'b1;
            w_iss0             = 1'b1;
        end else begin
            w_iss0 = 1'b1;
            w_iss1 = 1'b1;
        end
    end

    logic w_ld0_set, w_ld1_set;
    assign w_ld0_set = w_iss0 && (w_op0 == c_OP_LOAD) && (w_rd0 != 5'd0);
    assign w_ld1_set = w_iss1 && (w_op1 == c_OP_LOAD) && (w_rd1 != 5'd0);

    // ------------------------------------------------------------------
    // Scoreboard: counters age every cycle (stall or not); a new load
    // overrides the same-cycle decrement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_ld0_set && (w_rd0 == 5'(i))) begin
                    r_sb[i] <= c_LOAD_SET;
                end else if (w_ld1_set && (w_rd1 == 5'(i))) begin
                    r_sb[i] <= c_LOAD_SET;
                end else if (r_sb[i] != '0) begin
                    r_sb[i] <= r_sb[i] - c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue slot registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue0_valid <= 1'b0;
            r_issue0_instr <= '0;
            r_issue1_valid <= 1'b0;
            r_issue1_instr <= '0;
            r_issue_count  <= '0;
        end else if (!ex_stall) begin
            r_issue0_valid <= w_iss0;
            r_issue0_instr <= w_iss0 ? instruction0 : 32'd0;
            r_issue1_valid <= w_iss1;
            r_issue1_instr <= w_iss1 ? instruction1 : 32'd0;
            r_issue_count  <= r_issue_count + {31'd0, w_iss0} + {31'd0, w_iss1};
        end
    end

    assign issue0_valid = r_issue0_valid;
    assign issue0_instr = r_issue0_instr;
    assign issue1_valid = r_issue1_valid;
    assign issue1_instr = r_issue1_instr;
    assign issue_count  = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Self-checking bench for dual_issue_scheduler. Each step
//               drives a pair, checks the combinational control outputs,
//               queues the expected issue-slot contents and compares them
//               after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

    logic        clk;
    logic        rst;
    logic        nothing_filled;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        ex_stall;
    logic        freeze1;
    logic        freeze2;
    logic        dependency_on_ins2;
    logic        issue0_valid;
    logic [31:0] issue0_instr;
    logic        issue1_valid;
    logic [31:0] issue1_instr;
    logic [31:0] issue_count;

    dual_issue_scheduler #(.LOAD_LATENCY(3)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .nothing_filled     (nothing_filled),
        .instruction0       (instruction0),
        .instruction1       (instruction1),
        .ex_stall           (ex_stall),
        .freeze1            (freeze1),
        .freeze2            (freeze2),
        .dependency_on_ins2 (dependency_on_ins2),
        .issue0_valid       (issue0_valid),
        .issue0_instr       (issue0_instr),
        .issue1_valid       (issue1_valid),
        .issue1_instr       (issue1_instr),
        .issue_count        (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
        logic [31:0] cnt;
    } exp_t;

    exp_t q_exp[$];

    int n_total = 0;
    int n_bad   = 0;

    // Expected issue-slot state as the bench believes it should be.
    logic        m_v0  = 1'b0;
    logic [31:0] m_i0  = '0;
    logic        m_v1  = 1'b0;
    logic [31:0] m_i1  = '0;
    logic [31:0] m_cnt = '0;

    localparam logic [31:0] c_ADDI_X1_1 = 32'h0010_0093;
    localparam logic [31:0] c_ADDI_X2_2 = 32'h0020_0113;
    localparam logic [31:0] c_ADDI_X1_2 = 32'h0020_0093;
    localparam logic [31:0] c_ADDI_X7_1 = 32'h0010_0393;
    localparam logic [31:0] c_ADD_X2_X1 = 32'h0010_8133;
    localparam logic [31:0] c_LW_X3     = 32'h0000_a183;
    localparam logic [31:0] c_LW_X4     = 32'h0040_a203;
    localparam logic [31:0] c_LW_X5     = 32'h0001_2283;
    localparam logic [31:0] c_ADD_X4_X3 = 32'h0031_8233;
    localparam logic [31:0] c_ADD_X6_X5 = 32'h0052_8333;
    localparam logic [31:0] c_BEQ       = 32'h0000_0463;
    localparam logic [31:0] c_SW_X2     = 32'h0020_2023;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_slots(input exp_t e);
        chk("issue0_valid", 32'(issue0_valid), 32'(e.v0));
        chk("issue0_instr", issue0_instr, e.i0);
        chk("issue1_valid", 32'(issue1_valid), 32'(e.v1));
        chk("issue1_instr", issue1_instr, e.i1);
        chk("issue_count", issue_count, e.cnt);
    endtask

    // One cycle: drive, check controls, queue expected slots, compare after edge.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic nf, input logic st,
                        input logic ef1, input logic ef2, input logic edep, input int n);
        exp_t e;
        @(negedge clk);
        instruction0   = a;
        instruction1   = b;
        nothing_filled = nf;
        ex_stall       = st;
        #1;
        chk({tag, ".freeze1"}, 32'(freeze1), 32'(ef1));
        chk({tag, ".freeze2"}, 32'(freeze2), 32'(ef2));
        chk({tag, ".dep"}, 32'(dependency_on_ins2), 32'(edep));
        if (!st) begin
            m_v0  = (n >= 1);
            m_i0  = (n >= 1) ? a : 32'd0;
            m_v1  = (n == 2);
            m_i1  = (n == 2) ? b : 32'd0;
            m_cnt = m_cnt + 32'(n);
        end
        e = '{v0: m_v0, i0: m_i0, v1: m_v1, i1: m_i1, cnt: m_cnt};
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        chk_slots(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst            = 1'b1;
        nothing_filled = 1'b1;
        instruction0   = '0;
        instruction1   = '0;
        ex_stall       = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_v0  = 1'b0;
        m_i0  = '0;
        m_v1  = 1'b0;
        m_i1  = '0;
        m_cnt = '0;
        e = '{v0: m_v0, i0: m_i0, v1: m_v1, i1: m_i1, cnt: m_cnt};
        chk_slots(e);
        chk("rst.freeze1", 32'(freeze1), 32'd0);
        chk("rst.freeze2", 32'(freeze2), 32'd0);
        chk("rst.dep", 32'(dependency_on_ins2), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        nothing_filled = 1'b1;
        instruction0   = '0;
        instruction1   = '0;
        ex_stall       = 1'b0;
        do_reset();

        // Independent pair dual-issues
        step("indep", c_ADDI_X1_1, c_ADDI_X2_2, 0, 0, 0, 0, 0, 2);
        // RAW within pair
        step("raw", c_ADDI_X1_1, c_ADD_X2_X1, 0, 0, 0, 0, 1, 1);
        // WAW within pair
        step("waw", c_ADDI_X1_1, c_ADDI_X1_2, 0, 0, 0, 0, 1, 1);

        // Load-use: two freeze cycles, then the consumer issues
        step("lw", c_LW_X3, 32'd0, 0, 0, 0, 0, 1, 1);
        step("use1", c_ADD_X4_X3, 32'd0, 0, 0, 1, 0, 0, 0);
        step("use2", c_ADD_X4_X3, 32'd0, 0, 0, 1, 0, 0, 0);
        step("use3", c_ADD_X4_X3, 32'd0, 0, 0, 0, 0, 1, 1);

        // Memory and control conflicts
        step("2ld", c_LW_X3, c_LW_X4, 0, 0, 0, 0, 1, 1);
        step("st_ld", c_SW_X2, c_LW_X3, 0, 0, 0, 0, 1, 1);
        step("beq", c_BEQ, c_ADDI_X2_2, 0, 0, 0, 0, 1, 1);

        // Execute back-pressure holds the slots and count
        step("stall1", c_ADDI_X1_1, c_ADDI_X2_2, 0, 1, 0, 1, 0, 0);
        step("stall2", c_ADDI_X1_1, c_ADDI_X2_2, 0, 1, 0, 1, 0, 0);
        step("stall3", c_ADDI_X1_1, c_ADDI_X2_2, 0, 1, 0, 1, 0, 0);
        step("unstall", c_ADDI_X1_1, c_ADDI_X2_2, 0, 0, 0, 0, 0, 2);

        // Slot-1 load is scoreboarded; busy ins1 source splits the pair
        step("lw_s1", c_ADDI_X1_1, c_LW_X5, 0, 0, 0, 0, 0, 2);
        step("busy1", c_ADDI_X7_1, c_ADD_X6_X5, 0, 0, 0, 0, 1, 1);
        step("use5a", c_ADD_X6_X5, 32'd0, 0, 0, 1, 0, 0, 0);
        step("use5b", c_ADD_X6_X5, 32'd0, 0, 0, 0, 0, 1, 1);

        // Empty pair cases
        step("nf", c_ADDI_X1_1, c_ADDI_X2_2, 1, 0, 0, 0, 0, 0);
        step("i0z", 32'd0, c_ADDI_X2_2, 0, 0, 0, 0, 0, 0);
        // Stall with empty pair: no freeze2
        step("nf_st", 32'd0, 32'd0, 0, 1, 0, 0, 0, 0);

        // Reset discards a pending load
        step("lw_r", c_LW_X3, 32'd0, 0, 0, 0, 0, 1, 1);
        do_reset();
        step("post_rst", c_ADD_X4_X3, 32'd0, 0, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Sits directly downstream of the instruction fetch buffer and consumes its instruction0/instruction1 pair.
- Decodes both RV32I words and detects operand hazards against a load scoreboard, intra-pair conflicts and back-pressure from execute.
- Drives freeze1, freeze2 and dependency_on_ins2 back to the buffer.
- Registers 0, 1 or 2 instructions per cycle into the issue slots feeding execute.

Parameters:
- LOAD_LATENCY, 3, cycles from load issue until its rd is forwardable; legal range >=1. Scoreboard counter width is $clog2(LOAD_LATENCY+1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- nothing_filled  input  1  fetch buffer empty; pair invalid
- instruction0  input  32  oldest instruction; 0 = empty
- instruction1  input  32  next instruction; 0 = empty
- ex_stall  input  1  execute cannot accept new issue
- freeze1  output  1  ins0 operand hazard; buffer holds
- freeze2  output  1  execute back-pressure; buffer holds
- dependency_on_ins2  output  1  issue ins0 only; buffer slides by 1
- issue0_valid  output  1  slot-0 instruction valid
- issue0_instr  output  32  slot-0 instruction
- issue1_valid  output  1  slot-1 instruction valid
- issue1_instr  output  32  slot-1 instruction
- issue_count  output  32  total instructions issued; wraps at 2^32

Behaviour:
- Decode fields: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
- Source usage:
  - Both rs1 and rs2: 0110011, 0100011, 1100011.
  - rs1 only: 0010011, 0000011, 1100111.
  - No sources: 0110111, 0010111, 1101111.
- Writes rd: every opcode except 0100011 and 1100011. rd==x0 never counts as a write; rs==x0 never hazards.
- mem op = 0000011 or 0100011. ctrl op = 1100011, 1101111 or 1100111.
- Scoreboard:
  - One counter per x1..x31; a register is busy when its counter != 0.
  - All counters decrement by 1 each cycle while nonzero, including during ex_stall.
  - An issued load (slot 0 or slot 1) with rd!=0 sets counter[rd] = LOAD_LATENCY-1. The set wins over a same-cycle decrement.
  - Non-load writers are never scoreboarded; full forwarding is provided.
- v0 = !nothing_filled && instruction0!=0. v1 = v0 && instruction1!=0.
- Control outputs are combinational from the inputs and current state, evaluated in this priority:
  1. !v0: all control outputs 0; nothing issues.
  2. ex_stall: freeze2=1, others 0; nothing issues.
  3. Any ins0 source busy: freeze1=1, others 0; nothing issues.
  4. Otherwise dependency_on_ins2=1, ins0 issues alone, if any of the following holds:
     - !v1;
     - ins1 reads ins0.rd (RAW);
     - ins1.rd==ins0.rd, both nonzero (WAW);
     - both are mem ops;
     - ins0 is a ctrl op;
     - any ins1 source is busy.
  5. Else all control outputs 0; both instructions issue.
- freeze1, freeze2 and dependency_on_ins2 are mutually exclusive.
- Issue registers, updated at posedge clk:
  - rst: clears issue*_valid, issue*_instr, issue_count and all scoreboard counters.
  - ex_stall: issue registers hold their values.
  - Otherwise: issue0_valid/issue1_valid load this cycle's decision; the instr fields load instruction0/instruction1, or 0 when the slot is not valid.
  - issue_count adds 0, 1 or 2.
- Latency: a pair presented in cycle t appears on the issue ports after the edge ending cycle t.
- Load-use: a consumer of a slot-0 load presented the next cycle sees freeze1 for LOAD_LATENCY-1 cycles.
- Reset mid-operation: all pending loads are discarded; freeze1 is 0 in the first cycle after reset.

Test Plan:
- Independent pair: instruction0=0x00100093 (addi x1,x0,1), instruction1=0x00200113 (addi x2,x0,2) -> all control outputs 0; next cycle issue0_valid=1, issue1_valid=1, issue0_instr=0x00100093, issue1_instr=0x00200113; issue_count=2.
- RAW pair: addi x1,x0,1 with 0x00108133 (add x2,x1,x1) -> dependency_on_ins2=1; next cycle issue0_valid=1, issue1_valid=0, issue1_instr=0; issue_count +1.
- Load-use: issue 0x0000a183 (lw x3,0(x1)) alone; next cycle instruction0=0x00318233 (add x4,x3,x3) -> freeze1=1 for 2 cycles, then 0; add issues on the third cycle.
- Conflicts: two loads 0x0000a183/0x0040a203 -> dependency_on_ins2=1; instruction0=0x00000463 (beq) with any valid ins1 -> dependency_on_ins2=1.
- ex_stall=1 for 3 cycles with an independent pair -> freeze2=1 and issue ports/issue_count hold. Assert rst during a pending load -> counters clear; consumer shows freeze1=0 after reset.
- nothing_filled=1, or instruction0=0 -> all control outputs 0, issue*_valid=0 next cycle, issue_count unchanged.
